// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data width, parity and stop bits.
// A one-entry holding register behind a valid/ready handshake lets frames
// go out back to back with no idle gap. The line, busy and done outputs
// are registered copies of what the FSM presents, so tx has no
// combinational path from the inputs.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 1_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (BIT_PERIOD < 2) begin : g_bad_baud
    $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic                 tx_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic                 baud_end;
  logic                 frame_end;
  logic                 load;
  logic                 line_val;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == ST_STOP) && baud_end && (bit_cnt == STOP_LAST);
  assign tx_ready  = ~hold_full;
  assign tx        = tx_reg;
  assign tx_busy   = busy_reg;
  assign tx_done   = done_reg;

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, shifter load request and the line level for this state.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    line_val   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        line_val = 1'b0;
        if (baud_end) begin
          next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        line_val = shift_reg[0];
        if (baud_end && (bit_cnt == DATA_LAST)) begin
          next_state = (PARITY != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        line_val = par_bit;
        if (baud_end) begin
          next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        line_val = 1'b1;
        if (frame_end) begin
          if (hold_full) begin
            load       = 1'b1;
            next_state = ST_START;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Baud and bit counters plus the data shifter; parity is fixed at load time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else if (load) begin
      shift_reg <= hold_data;
      par_bit   <= (PARITY == 1) ? ~^hold_data : ^hold_data;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else if (state != ST_IDLE) begin
      if (baud_end) begin
        baud_cnt <= '0;
        if (state == ST_DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= (bit_cnt == DATA_LAST) ? 4'd0 : bit_cnt + 4'd1;
        end else if (state == ST_STOP) begin
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          bit_cnt <= '0;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  // Holding register: filled on handshake, emptied when the shifter takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Registered outputs so the line never glitches on input changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      tx_reg   <= line_val;
      busy_reg <= (state != ST_IDLE);
      done_reg <= frame_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7O2) share a
// clock and reset. Expected line, busy and done waveforms are built per
// sample from the frame rules and compared cycle by cycle.
module tb_uart_tx_frame;

  localparam int BP = 1_000_000 / 9600;
  localparam int DB [4]  = '{8, 8, 8, 7};
  localparam int PAR [4] = '{0, 2, 1, 1};
  localparam int SB [4]  = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v    [4];
  logic [8:0] d    [4];
  logic       rdy  [4];
  logic       txl  [4];
  logic       busy [4];
  logic       done [4];

  int total = 0;
  int bad   = 0;

  bit exp_tx   [$];
  bit exp_busy [$];
  bit exp_done [$];

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(v[0]), .tx_data(d[0][7:0]),
    .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(v[1]), .tx_data(d[1][7:0]),
    .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(v[2]), .tx_data(d[2][7:0]),
    .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  uart_tx_frame #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(v[3]), .tx_data(d[3][6:0]),
    .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
      exp_done.push_back(1'b0);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits.
  task automatic addFrame(input int idx, input logic [8:0] data);
    bit bits [$];
    int ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DB[idx]; i++) begin
      bits.push_back(data[i]);
      if (data[i]) ones++;
    end
    if (PAR[idx] == 1) bits.push_back((ones % 2) == 0);
    else if (PAR[idx] == 2) bits.push_back((ones % 2) == 1);
    for (int s = 0; s < SB[idx]; s++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < BP; c++) begin
        exp_tx.push_back(bits[b]);
        exp_busy.push_back(1'b1);
        exp_done.push_back((b == bits.size() - 1) && (c == BP - 1));
      end
    end
  endtask

  // Compares every sample after the first handshake edge with the model.
  task automatic watchLine(input int idx, input int n, input string name);
    int etx, ebusy, edone;
    etx = 0; ebusy = 0; edone = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (txl[idx] !== exp_tx[k]) etx++;
      if (busy[idx] !== exp_busy[k]) ebusy++;
      if (done[idx] !== exp_done[k]) edone++;
    end
    checkOutput({name, "_tx_bad_cycles"}, 32'(etx), 32'd0);
    checkOutput({name, "_busy_bad_cycles"}, 32'(ebusy), 32'd0);
    checkOutput({name, "_done_bad_cycles"}, 32'(edone), 32'd0);
  endtask

  // Presents data and returns just after the handshake edge.
  task automatic applyStimulus(input int idx, input logic [8:0] data, output bit ok);
    @(negedge clk);
    v[idx] = 1'b1;
    d[idx] = data;
    ok = 1'b0;
    for (int w = 0; w < 4000; w++) begin
      if (rdy[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("handshake_wait", 32'(ok), 32'd1);
    if (ok) @(posedge clk);
  endtask

  task automatic runTest(input int idx, input logic [8:0] d0, input logic [8:0] d1,
                         input int nframes, input bit scramble, input string name);
    bit ok;
    int n;
    exp_tx.delete();
    exp_busy.delete();
    exp_done.delete();
    addIdle(2);
    addFrame(idx, d0);
    if (nframes == 2) addFrame(idx, d1);
    addIdle(4);
    n = exp_tx.size();
    applyStimulus(idx, d0, ok);
    if (!ok) begin
      v[idx] = 1'b0;
      return;
    end
    fork
      watchLine(idx, n, name);
      begin
        int waited;
        @(negedge clk);
        if (nframes == 2) begin
          d[idx] = d1;
          waited = 0;
          while (rdy[idx] !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
          end
          @(posedge clk);
          checkOutput({name, "_hs2_delay"}, 32'(waited + 1), 32'd2);
          @(negedge clk);
          v[idx] = 1'b0;
          checkOutput({name, "_ready_held"}, 32'(rdy[idx]), 32'd0);
        end else begin
          v[idx] = 1'b0;
          checkOutput({name, "_ready_full"}, 32'(rdy[idx]), 32'd0);
        end
        if (scramble) begin
          repeat (n - 4) begin
            @(negedge clk);
            d[idx] = 9'($urandom);
          end
        end
      end
    join
  endtask

  // Bounds the whole run so a stuck design still reaches the summary.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed cases, then randomized frames.
  initial begin
    bit ok;
    int lows, dones;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0;
      d[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("reset_state%0d", i),
                  32'({txl[i], busy[i], rdy[i], done[i]}), 32'b1010);
    rst_n = 1'b1;
    @(negedge clk);

    runTest(0, 9'h0A5, 9'h000, 1, 1'b0, "t1_8n1_a5");
    runTest(1, 9'h007, 9'h000, 1, 1'b0, "t2_even_07");
    runTest(2, 9'h007, 9'h000, 1, 1'b0, "t2_odd_07");
    runTest(3, 9'h055, 9'h000, 1, 1'b0, "t3_7o2_55");
    runTest(0, 9'h012, 9'h034, 2, 1'b0, "t4_b2b");

    applyStimulus(0, 9'h0FF, ok);
    @(negedge clk);
    v[0] = 1'b0;
    repeat (450) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t5_after_reset", 32'({txl[0], busy[0], rdy[0], done[0]}), 32'b1010);
    rst_n = 1'b1;
    lows = 0;
    dones = 0;
    repeat (1200) begin
      @(negedge clk);
      if (txl[0] !== 1'b1) lows++;
      if (done[0] !== 1'b0) dones++;
    end
    checkOutput("t5_no_done", 32'(dones), 32'd0);
    checkOutput("t5_line_idle", 32'(lows), 32'd0);
    runTest(0, 9'h000, 9'h000, 1, 1'b0, "t5_clean_00");

    runTest(0, 9'h03C, 9'h000, 1, 1'b1, "t6_hold_3c");

    for (int r = 0; r < 6; r++) begin
      int idx;
      idx = int'($urandom_range(0, 3));
      runTest(idx, 9'($urandom), 9'($urandom), int'($urandom_range(1, 2)), 1'b0,
              $sformatf("rnd%0d_i%0d", r, idx));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter for the cold-storage sensor link. It supersedes the fixed 8N1 transmitter and adds configurable data width, parity and stop-bit count. It uses a valid/ready input handshake with a one-entry holding register, so back-to-back frames go out with no idle gap. It sits between the DHT11 sample formatter and the board TX pin.

Parameters:
CLK_FREQ, 1_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in bits/s. BIT_PERIOD = CLK_FREQ/BAUD_RATE, truncated, which is 104 at defaults. Must be >= 2.
DATA_BITS, 8, data bits per frame. Legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even. Value 3 is illegal (elaboration error).
STOP_BITS, 1, stop bits per frame. Legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
tx_valid  input  1  upstream has a byte on tx_data.
tx_data  input  DATA_BITS  payload; sampled on the handshake cycle only.
tx_ready  output  1  holding register empty; a transfer occurs when tx_valid && tx_ready at a clk edge.
tx  output  1  serial line; idles high.
tx_busy  output  1  high while any bit of a frame is on the line.
tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (rst_n low at an edge): tx=1, tx_busy=0, tx_done=0, tx_ready=1. Holding register is cleared, state=IDLE, bit and baud counters=0. This applies mid-frame: the line returns high on the next edge and the partial frame is abandoned.
- Holding register: written on handshake. tx_ready=0 while it is full. It is emptied when the shifter loads it.
- FSM states:
  - IDLE: if the holding register is full, load the shifter, clear the holding register and go to START. Start-bit low appears the cycle after load, so it is 2 cycles after a handshake made in IDLE.
  - START: drive tx=0.
  - DATA: drive data bits LSB first, for DATA_BITS bits.
  - PARITY: present only if PARITY!=0. Odd mode drives ~^data; even mode drives ^data.
  - STOP: drive tx=1 for STOP_BITS bits.
- Bit timing: each bit (start, data, parity, stop) holds tx for exactly BIT_PERIOD cycles. The baud counter runs 0..BIT_PERIOD-1 and the bit advances on terminal count.
- Frame length: BIT_PERIOD*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles. At defaults this is 1040.
- End of frame: in the last cycle of the final stop bit, tx_done=1.
  - If the holding register is full, the shifter loads it on that same edge. The next cycle is a start bit, with no idle cycle, and tx_busy stays 1.
  - Otherwise go to IDLE; tx_busy falls on the next cycle.
- tx_busy is 1 from the first start-bit cycle through the last stop-bit cycle inclusive.
- Simultaneous handshake and shifter load in the same cycle: the load takes the old holding contents and the holding register captures the new data. tx_ready stays 0.
- tx_data is only sampled on the handshake cycle. Later changes to tx_data do not affect a frame in flight.
- tx is registered, with no combinational path from inputs to tx.
- tx_valid with tx_ready=0 is held off. No data is lost and no overflow flag exists.

Test Plan:
1. Defaults (8N1, BIT_PERIOD=104). Handshake 0xA5 in IDLE.
   - Required: tx low for 104 cycles, then bits 1,0,1,0,0,1,0,1 at 104 cycles each, then high for 104 cycles.
   - tx_done pulses exactly 1041 cycles after the handshake edge; tx_busy high for 1040 cycles.
2. PARITY=2, DATA_BITS=8. Send 0x07.
   - Required: parity bit = 1 and frame = 1144 cycles.
   - With PARITY=1, the same data gives parity bit = 0.
3. DATA_BITS=7, PARITY=1, STOP_BITS=2. Send 7'h55.
   - Required: data 1,0,1,0,1,0,1, parity 1, two stop bits high, frame = 11*104 cycles.
4. Back-to-back. Hold tx_valid high with 0x12 then 0x34.
   - Required: second handshake occurs the cycle after the first load, and tx_ready=0 thereafter.
   - The 0x34 start bit begins the cycle after 0x12's tx_done; tx_busy never drops between the frames.
5. Reset mid-frame. Assert rst_n=0 for 1 cycle during data bit 3 of 0xFF.
   - Required: tx=1, tx_busy=0, tx_ready=1 after the edge, and no tx_done pulse.
   - A new handshake of 0x00 produces a clean full frame.
6. Holding hazard. Change tx_data every cycle after the handshake of 0x3C.
   - Required: the line shows 0x3C exactly, LSB first.
